pmem_line_responder: RTL and testbench
======================================

Name: pmem_line_responder

Overview:
- Line-granularity physical-memory responder: the slave end of the cache's pmem_* interface (pmem_read/pmem_write/pmem_address/pmem_wdata in, pmem_resp/pmem_rdata out).
- Holds a LINES-deep array of 256-bit lines and answers each read or write after a fixed, parameterised latency with a single-cycle pmem_resp pulse.
- Sits below the cache in simulation and FPGA builds; also provides protocol-error and transaction-count debug outputs.

Parameters:
- LINES, 256, number of 32-byte lines stored; power of two, ≥2; IDX_W = log2(LINES).
- LATENCY, 10, cycles from request sample to pmem_resp; must be ≥1.
- CNT_W, 16, width of the transaction counters.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- pmem_read  in  1  line read request, held until pmem_resp
- pmem_write  in  1  line write request, held until pmem_resp
- pmem_address  in  32  byte address; bits [4:0] ignored
- pmem_wdata  in  256  write line data
- pmem_resp  out  1  one-cycle completion pulse
- pmem_rdata  out  256  read line data, valid in the pmem_resp cycle of a read
- proto_err  out  1  sticky protocol-violation flag
- rd_count  out  CNT_W  completed reads, saturating
- wr_count  out  CNT_W  completed writes, saturating

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; pmem_resp=0, pmem_rdata=0, proto_err=0, rd_count=0, wr_count=0.
  - Array contents are not reset and are retained.
  - Reset mid-transaction: returns to IDLE, no resp, pending write not committed.
- Index: idx = pmem_address[5+IDX_W-1:5]. Address bits above the index are ignored, so addresses alias modulo LINES*32 bytes.
- FSM IDLE / WAIT / RESP:
  - IDLE: if pmem_read|pmem_write at an edge, latch op, idx and wdata; load cnt=LATENCY-1; go to WAIT, or straight to RESP if LATENCY=1.
  - WAIT: cnt decrements each cycle; go to RESP when cnt reaches 0.
  - RESP: pmem_resp=1 for exactly one cycle, then back to IDLE.
  - Timing: request first seen in cycle 0 gives pmem_resp high in cycle LATENCY and low in every other cycle.
- Read: pmem_rdata is registered, loaded from array[idx] on the edge entering RESP. It holds its value after resp until the next read's RESP and is unchanged by writes.
- Write: array[idx] <= latched wdata on the edge leaving RESP, so a read issued immediately afterwards sees the new data.
- Back-to-back: a request present in the first IDLE cycle after RESP is accepted there (a writeback followed by a fill takes 2*(LATENCY+1) cycles).
- Latched operands: address and wdata changes after acceptance are ignored.
- Abort: if both pmem_read and pmem_write drop while in WAIT, return to IDLE next cycle, with no resp, no array update and no count.
- Protocol violations:
  - pmem_read and pmem_write both high in IDLE: service as a write and set proto_err.
  - Request switches between read and write during WAIT: set proto_err; the latched op still completes.
  - proto_err clears only on reset.
- Counters: rd_count or wr_count increments on the RESP cycle and saturates at 2^CNT_W-1.

Test Plan:
- LATENCY=10: write line 0x0000_0040 with wdata=256'hA5…A5, then read the same address → resp exactly 10 cycles after each request sample; rdata=A5…A5; wr_count=1, rd_count=1.
- Alias with LINES=256: write 0x0000_2040 (idx 2) = pattern P, read 0x0000_0040 → rdata=P; read 0x0000_0060 (idx 3, never written) → X/initial content, no proto_err.
- Byte-offset ignore: write 0x0000_0100, read 0x0000_011F → same line returned; pmem_resp is a single-cycle pulse both times.
- Abort: start a read, drop pmem_read at cycle 4 → no resp within 2*LATENCY cycles, rd_count=0; a following read completes normally.
- Reset mid-write at cycle 5 → resp never asserts; a later read of that line returns the old data; all outputs 0 the cycle after reset.
- Assert read and write together → serviced as a write with resp at cycle LATENCY; proto_err=1 and stays 1 until rst_n=0. With LATENCY=1 → resp the cycle after the sample.

Source files
------------

// File: rtl/pmem_line_responder.sv
// Line-granularity physical memory responder for the cache pmem_* port.
// Answers each line read/write after LATENCY cycles with a one-cycle resp.
module pmem_line_responder #(
    parameter int LINES   = 256,
    parameter int LATENCY = 10,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pmem_read,
    input  logic             pmem_write,
    input  logic [31:0]      pmem_address,
    input  logic [255:0]     pmem_wdata,
    output logic             pmem_resp,
    output logic [255:0]     pmem_rdata,
    output logic             proto_err,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int LAT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_op_wr;
    logic [IDX_W-1:0]   r_idx;
    logic [255:0]       r_wdata;
    logic [LAT_W-1:0]   r_cnt;
    logic [255:0]       r_rdata;
    logic               r_err;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [255:0]       r_mem [LINES];

    logic               w_req;
    logic               w_accept;
    logic               w_err_set;
    logic [IDX_W-1:0]   w_addr_idx;
    logic [IDX_W-1:0]   w_rd_idx;
    logic               w_rd_op;
    logic               w_unused;

    assign w_req      = pmem_read | pmem_write;
    assign w_addr_idx = pmem_address[5 +: IDX_W];
    assign w_unused   = ^{pmem_address[31:5+IDX_W], pmem_address[4:0]};

    // With LATENCY=1 RESP is entered straight from IDLE, before the latch
    assign w_rd_idx = (r_state == S_IDLE) ? w_addr_idx : r_idx;
    assign w_rd_op  = (r_state == S_IDLE) ? !pmem_write : !r_op_wr;

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_err_set = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_accept  = 1'b1;
                    w_err_set = pmem_read & pmem_write;
                    w_next    = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_next = S_IDLE;
                end else begin
                    w_err_set = r_op_wr ? pmem_read : pmem_write;
                    if (r_cnt == LAT_W'(1)) begin
                        w_next = S_RESP;
                    end
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_next == S_RESP && w_rd_op) begin
                r_rdata <= r_mem[w_rd_idx];
            end
            if (r_state == S_RESP) begin
                if (r_op_wr) begin
                    if (r_wr_cnt != '1) begin
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                    end
                end else if (r_rd_cnt != '1) begin
                    r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_wr <= pmem_write;
            r_idx   <= w_addr_idx;
            r_wdata <= pmem_wdata;
            r_cnt   <= LAT_W'(LATENCY - 1);
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - LAT_W'(1);
        end
    end

    // Commit on the edge leaving RESP; a reset on that edge drops the write
    always_ff @(posedge clk) begin
        if (rst_n && r_state == S_RESP && r_op_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign pmem_resp  = (r_state == S_RESP);
    assign pmem_rdata = r_rdata;
    assign proto_err  = r_err;
    assign rd_count   = r_rd_cnt;
    assign wr_count   = r_wr_cnt;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder: latency, aliasing, abort,
// reset, protocol errors, LATENCY=1 and counter saturation.
module tb_pmem_line_responder;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         a_rst_n, a_read, a_write, a_resp, a_err;
    logic [31:0]  a_addr;
    logic [255:0] a_wdata, a_rdata;
    logic [15:0]  a_rdc, a_wrc;

    logic         b_rst_n, b_read, b_write, b_resp, b_err;
    logic [31:0]  b_addr;
    logic [255:0] b_wdata, b_rdata;
    logic [1:0]   b_rdc, b_wrc;

    int n_chk = 0;
    int n_err = 0;

    logic [255:0] PA5, PP, PQ, PR, PS, PT, PU, rd;

    always #5 clk = ~clk;

    pmem_line_responder #(.LINES(256), .LATENCY(LAT), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(a_rst_n),
        .pmem_read(a_read), .pmem_write(a_write),
        .pmem_address(a_addr), .pmem_wdata(a_wdata),
        .pmem_resp(a_resp), .pmem_rdata(a_rdata),
        .proto_err(a_err), .rd_count(a_rdc), .wr_count(a_wrc)
    );

    pmem_line_responder #(.LINES(2), .LATENCY(1), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(b_rst_n),
        .pmem_read(b_read), .pmem_write(b_write),
        .pmem_address(b_addr), .pmem_wdata(b_wdata),
        .pmem_resp(b_resp), .pmem_rdata(b_rdata),
        .proto_err(b_err), .rd_count(b_rdc), .wr_count(b_wrc)
    );

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Request in cycle 0; operands scrambled after acceptance
    task automatic txn(input logic r, input logic w, input logic [31:0] ad,
                       input logic [255:0] wd, input string tag,
                       output logic [255:0] rdat);
        int at;
        at = -1;
        rdat = '0;
        a_read = r; a_write = w; a_addr = ad; a_wdata = wd;
        for (int i = 1; i <= LAT + 4 && at < 0; i++) begin
            tick;
            if (i == 1) begin
                a_addr  = ad ^ 32'h0000_1FE0;
                a_wdata = ~wd;
            end
            if (a_resp) at = i;
        end
        rdat = a_rdata;
        a_read = 1'b0;
        a_write = 1'b0;
        chk({tag, " latency"}, 256'(at), 256'(LAT));
        tick;
        chk({tag, " pulse"}, 256'(a_resp), 256'(0));
    endtask

    initial begin
        int n;
        int at;
        PA5 = {32{8'hA5}};
        PP  = {8{32'h1234_5678}};
        PQ  = {8{32'hDEAD_BEEF}};
        PR  = {4{64'h0F0F_1111_2222_3333}};
        PS  = {8{32'h5555_AAAA}};
        PT  = {8{32'hC0FF_EE00}};
        PU  = {8{32'h0BAD_F00D}};
        a_rst_n = 1'b0; a_read = 1'b0; a_write = 1'b0;
        a_addr = '0; a_wdata = '0;
        b_rst_n = 1'b0; b_read = 1'b0; b_write = 1'b0;
        b_addr = '0; b_wdata = PU;
        repeat (3) tick;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        chk("rst resp", 256'(a_resp), 256'(0));
        chk("rst rdata", a_rdata, 256'(0));
        chk("rst err", 256'(a_err), 256'(0));
        chk("rst rdc", 256'(a_rdc), 256'(0));
        chk("rst wrc", 256'(a_wrc), 256'(0));

        txn(1'b0, 1'b1, 32'h0000_0040, PA5, "wr40", rd);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, "rd40", rd);
        chk("rd40 data", rd, PA5);
        chk("cnt1 rd", 256'(a_rdc), 256'(1));
        chk("cnt1 wr", 256'(a_wrc), 256'(1));

        txn(1'b0, 1'b1, 32'h0000_2040, PP, "wr2040", rd);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, "alias", rd);
        chk("alias data", rd, PP);
        txn(1'b1, 1'b0, 32'h0000_0060, '0, "rd60", rd);
        chk("rd60 err", 256'(a_err), 256'(0));

        txn(1'b0, 1'b1, 32'h0000_0100, PQ, "wr100", rd);
        txn(1'b1, 1'b0, 32'h0000_011F, '0, "rd11F", rd);
        chk("offset data", rd, PQ);
        txn(1'b0, 1'b1, 32'h0000_0080, PR, "wr80", rd);
        txn(1'b1, 1'b0, 32'h0000_0080, '0, "rd80", rd);
        chk("b2b data", rd, PR);
        chk("cnt5 rd", 256'(a_rdc), 256'(5));
        chk("cnt5 wr", 256'(a_wrc), 256'(4));

        a_read = 1'b1;
        a_addr = 32'h0000_0040;
        repeat (4) tick;
        a_read = 1'b0;
        n = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            tick;
            if (a_resp) n++;
        end
        chk("abort resp", 256'(n), 256'(0));
        chk("abort rdc", 256'(a_rdc), 256'(5));
        txn(1'b1, 1'b0, 32'h0000_0040, '0, "post abort", rd);
        chk("post abort data", rd, PP);

        a_write = 1'b1;
        a_addr = 32'h0000_0040;
        a_wdata = PS;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (a_resp) n++;
        end
        a_rst_n = 1'b0;
        a_write = 1'b0;
        tick;
        a_rst_n = 1'b1;
        chk("mid rst resp", 256'(a_resp), 256'(0));
        chk("mid rst rdata", a_rdata, 256'(0));
        chk("mid rst rdc", 256'(a_rdc), 256'(0));
        chk("mid rst wrc", 256'(a_wrc), 256'(0));
        for (int i = 0; i < 2 * LAT; i++) begin
            tick;
            if (a_resp) n++;
        end
        chk("mid rst no resp", 256'(n), 256'(0));
        txn(1'b1, 1'b0, 32'h0000_0040, '0, "old data", rd);
        chk("old data val", rd, PP);

        txn(1'b1, 1'b1, 32'h0000_00C0, PT, "both", rd);
        chk("both err", 256'(a_err), 256'(1));
        chk("both wrc", 256'(a_wrc), 256'(1));
        txn(1'b1, 1'b0, 32'h0000_00C0, '0, "rdC0", rd);
        chk("both as write", rd, PT);
        txn(1'b0, 1'b1, 32'h0000_00E0, PU, "wrE0", rd);
        chk("rdata held", a_rdata, PT);
        chk("err sticky", 256'(a_err), 256'(1));
        a_rst_n = 1'b0;
        tick;
        a_rst_n = 1'b1;
        chk("err cleared", 256'(a_err), 256'(0));

        a_read = 1'b1;
        a_addr = 32'h0000_0040;
        at = -1;
        for (int i = 1; i <= LAT + 4 && at < 0; i++) begin
            tick;
            if (i == 3) begin
                a_read = 1'b0;
                a_write = 1'b1;
            end
            if (a_resp) at = i;
        end
        rd = a_rdata;
        a_read = 1'b0;
        a_write = 1'b0;
        chk("switch latency", 256'(at), 256'(LAT));
        chk("switch data", rd, PP);
        chk("switch err", 256'(a_err), 256'(1));
        tick;
        chk("switch rdc", 256'(a_rdc), 256'(1));
        chk("switch wrc", 256'(a_wrc), 256'(0));

        b_read = 1'b1;
        b_write = 1'b1;
        tick;
        chk("lat1 resp", 256'(b_resp), 256'(1));
        b_read = 1'b0;
        b_write = 1'b0;
        tick;
        chk("lat1 pulse", 256'(b_resp), 256'(0));
        chk("lat1 err", 256'(b_err), 256'(1));
        b_read = 1'b1;
        repeat (8) tick;
        b_read = 1'b0;
        chk("lat1 data", b_rdata, PU);
        chk("sat rdc", 256'(b_rdc), 256'(3));
        chk("sat wrc", 256'(b_wrc), 256'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
